instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Converts decoded instruction requests (operation class, immediate flag, register fields, immediate/target) into 32-bit instruction words carrying the core's 5-bit opcode.
- It is the producing end of the opcode decoder that feeds the control path.
- Sits between the test/program sequencer and instruction memory load logic.
- Requests arrive on a valid/ready handshake, are encoded, and are buffered in a small FIFO drained by a second valid/ready handshake.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, at least 2).
- ERR_W, 8, width of the saturating illegal-request counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when high with in_valid
- op_class  input  4  0 add, 1 sub, 2 mult, 3 div, 4 and, 5 or, 6 xor, 7 bgt, 8 slt, 9 lw, 10 sw, 11 beq, 12 bne, 13 jr, 14 j, 15 illegal
- imm_flag  input  1  immediate variant; legal only for classes 0-5
- rd  input  5  destination register
- rs  input  5  source register 1
- rt  input  5  source register 2
- imm  input  27  immediate in [16:0]; jump target in [26:0]
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer accepts head
- out_instr  output  32  encoded instruction at FIFO head
- err_pulse  output  1  one-cycle pulse on an accepted illegal request
- err_count  output  ERR_W  saturating count of illegal requests
- level  output  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: in_ready=1, out_valid=0, out_instr=0, err_pulse=0, err_count=0, level=0. FIFO pointers cleared and contents discarded, including mid-drain.
- Opcode map (bits [31:27]):
  - add 00100, addi 01100, sub 00101, subi 01101, mult 00110, multi 01110, div 00111, divi 01111
  - and 00001, andi 01001, or 00010, ori 01010, xor 00011
  - bgt 10000, slt 10001, lw 10010, sw 10011, beq 10100, bne 10101, jr 10110, j 10111
  - For classes 0-5, imm_flag sets opcode bit 3.
- R format (classes 0-6 with imm_flag=0, 7, 8): {op, rd, rs, rt, 12'b0}.
- I format (classes 0-5 with imm_flag=1, 9-12): {op, rd, rs, imm[16:0]}.
- jr: {op, 5'b0, rs, 17'b0}.
- j: {op, imm[26:0]}.
- Illegal requests are class 15, or class 6-14 with imm_flag=1. They are accepted (handshake completes), not written to the FIFO, and raise err_pulse on the next cycle. err_count increments and saturates at all-ones.
- in_ready = (level != DEPTH). No bypass: there is no push into a full FIFO even when a pop occurs in the same cycle.
- Latency: a request accepted at edge N is encoded combinationally and written at edge N. out_valid is high after N, i.e. 1 cycle when the FIFO was empty.
- Pop on out_valid & out_ready. Simultaneous push and pop when 0<level<DEPTH leaves level unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- out_instr shows the head entry. It is held stable while out_valid & !out_ready, and is 0 when empty.
- Request inputs are ignored when in_valid=0.

Optional Feature:
- Macro: INSTR_ENC_ERR_CNT_EN.
- Defined: err_count behaves as above.
- Undefined: err_count is tied to 0 with no counter logic. err_pulse is unaffected.

Test Plan:
- Reset, then add rd=3 rs=1 rt=2 -> out_instr=0x20C22000, out_valid 1 cycle after accept, level=1.
- addi (class 0, imm_flag=1) rd=3 rs=1 imm=5 -> 0x60C20005. jr rs=31 -> 0xB03E0000. j imm=0x0000100 -> 0xB8000100.
- Push 5 requests with out_ready=0 and DEPTH=4 -> in_ready drops after the 4th, level=4. Raise out_ready -> 4 words emerge in order, then level=0, out_valid=0.
- Full FIFO with in_valid=1 and out_ready=1 in the same cycle -> the pop occurs, the request is not accepted that cycle, level=3, and the request is accepted next cycle.
- xor with imm_flag=1, then class 15 -> two err_pulses, err_count=2, no FIFO writes. With the macro undefined -> err_count stays 0.
- Assert rst with level=3 mid-drain -> next cycle out_valid=0, level=0, err_count=0, in_ready=1.

Source files
------------

// File: rtl/instr_encoder.sv
// Encodes decoded instruction requests into 32-bit words and queues them in a small FIFO.
// Optional saturating illegal-request counter enabled by defining INSTR_ENC_ERR_CNT_EN.
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               op_class,
  input  logic                     imm_flag,
  input  logic [4:0]               rd,
  input  logic [4:0]               rs,
  input  logic [4:0]               rt,
  input  logic [26:0]              imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic                     err_pulse,
  output logic [ERR_W-1:0]         err_count,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [4:0]  op;
  logic        illegal;
  logic [31:0] enc;
  logic        accept, push, pop;

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          err_pulse_q, err_pulse_d;

  always_comb begin
    op      = 5'b00000;
    illegal = 1'b0;
    case (op_class)
      4'd0:    op = 5'b00100;
      4'd1:    op = 5'b00101;
      4'd2:    op = 5'b00110;
      4'd3:    op = 5'b00111;
      4'd4:    op = 5'b00001;
      4'd5:    op = 5'b00010;
      4'd6:    op = 5'b00011;
      4'd7:    op = 5'b10000;
      4'd8:    op = 5'b10001;
      4'd9:    op = 5'b10010;
      4'd10:   op = 5'b10011;
      4'd11:   op = 5'b10100;
      4'd12:   op = 5'b10101;
      4'd13:   op = 5'b10110;
      4'd14:   op = 5'b10111;
      default: illegal = 1'b1;
    endcase
    // Only arithmetic/logic classes have an immediate variant.
    if (op_class <= 4'd5) op[3] = imm_flag;
    else if (imm_flag)    illegal = 1'b1;

    case (op_class)
      4'd13:                 enc = {op, 5'b0, rs, 17'b0};
      4'd14:                 enc = {op, imm};
      4'd9, 4'd10,
      4'd11, 4'd12:          enc = {op, rd, rs, imm[16:0]};
      default:               enc = imm_flag ? {op, rd, rs, imm[16:0]}
                                            : {op, rd, rs, rt, 12'b0};
    endcase
  end

  assign in_ready  = (level_q != FULL);
  assign out_valid = (level_q != '0);
  assign accept    = in_valid & in_ready;
  assign push      = accept & ~illegal;
  assign pop       = out_valid & out_ready;
  assign out_instr = out_valid ? mem_q[rd_ptr_q] : 32'b0;
  assign level     = level_q;
  assign err_pulse = err_pulse_q;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = enc;
    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    level_d     = level_q + LW'(push) - LW'(pop);
    err_pulse_d = accept & illegal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      err_pulse_q <= err_pulse_d;
    end
  end

`ifdef INSTR_ENC_ERR_CNT_EN
  logic [ERR_W-1:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (err_pulse_d && (err_count_q != '1)) err_count_d = err_count_q + ERR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) err_count_q <= '0;
    else     err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed steps plus random traffic against a queue model.
module tb_instr_encoder;
  localparam int DEPTH = 4;
  localparam int ERR_W = 8;

  logic        clk, rst, in_valid, in_ready, imm_flag;
  logic [3:0]  op_class;
  logic [4:0]  rd, rs, rt;
  logic [26:0] imm;
  logic        out_valid, out_ready, err_pulse;
  logic [31:0] out_instr;
  logic [ERR_W-1:0] err_count;
  logic [2:0]  level;

  instr_encoder #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_class(op_class), .imm_flag(imm_flag), .rd(rd), .rs(rs), .rt(rt), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .err_pulse(err_pulse), .err_count(err_count), .level(level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [31:0] q[$];
  int          m_cnt   = 0;
  bit          m_pulse = 0;
  int          base_op [16] = '{4, 5, 6, 7, 1, 2, 3, 16, 17, 18, 19, 20, 21, 22, 23, 0};

  function automatic bit ref_illegal(int cls, bit immf);
    return (cls == 15) || (cls >= 6 && immf);
  endfunction

  function automatic logic [31:0] ref_enc(int cls, bit immf, int r_d, int r_s, int r_t, int im);
    int unsigned o;
    o = base_op[cls] + ((cls <= 5 && immf) ? 8 : 0);
    if (cls == 14) return (o << 27) | (im & 32'h07FF_FFFF);
    if (cls == 13) return (o << 27) | (r_s << 17);
    if ((cls <= 5 && immf) || (cls >= 9 && cls <= 12))
      return (o << 27) | (r_d << 22) | (r_s << 17) | (im & 32'h1FFFF);
    return (o << 27) | (r_d << 22) | (r_s << 17) | (r_t << 12);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Predict the coming edge from the model, take the edge, then compare everything.
  task automatic cyc();
    bit acc, pop;
    if (rst) begin
      q.delete(); m_cnt = 0; m_pulse = 0;
    end else begin
      acc = in_valid && (q.size() != DEPTH);
      pop = (q.size() != 0) && out_ready;
      if (pop) void'(q.pop_front());
      m_pulse = acc && ref_illegal(op_class, imm_flag);
      if (acc && !m_pulse) q.push_back(ref_enc(op_class, imm_flag, rd, rs, rt, imm));
`ifdef INSTR_ENC_ERR_CNT_EN
      if (m_pulse && m_cnt < 255) m_cnt++;
`endif
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("level",     32'(level),     32'(q.size()));
    chk("in_ready",  32'(in_ready),  32'(q.size() != DEPTH));
    chk("out_instr", out_instr,      (q.size() != 0) ? q[0] : 32'h0);
    chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
    chk("err_count", 32'(err_count), 32'(m_cnt));
  endtask

  task automatic set_req(int cls, bit immf, int r_d, int r_s, int r_t, int im);
    in_valid = 1'b1;
    op_class = 4'(cls); imm_flag = immf;
    rd = 5'(r_d); rs = 5'(r_s); rt = 5'(r_t); imm = 27'(im);
  endtask

  task automatic rand_legal();
    int cls;
    cls = $urandom_range(0, 14);
    set_req(cls, (cls <= 5) ? $urandom_range(0, 1) : 0, $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 31), $urandom);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_req(0, 0, 0, 0, 0, 0); in_valid = 1'b0;
    #1;
    cyc(); cyc();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_level", 32'(level), 32'd0);
    rst = 1'b0;

    // Directed encodings
    set_req(0, 0, 3, 1, 2, 0); cyc(); in_valid = 1'b0;
    chk("add_word", out_instr, 32'h20C2_2000);
    chk("add_lat_valid", 32'(out_valid), 32'd1);
    chk("add_level", 32'(level), 32'd1);
    out_ready = 1'b1; cyc(); out_ready = 1'b0;

    set_req(0, 1, 3, 1, 9, 5); cyc(); in_valid = 1'b0;
    chk("addi_word", out_instr, 32'h60C2_0005);
    out_ready = 1'b1; cyc(); out_ready = 1'b0;

    set_req(13, 0, 7, 31, 5, 27'h7ABCD); cyc(); in_valid = 1'b0;
    chk("jr_word", out_instr, 32'hB03E_0000);
    out_ready = 1'b1; cyc(); out_ready = 1'b0;

    set_req(14, 0, 4, 4, 4, 27'h0000100); cyc(); in_valid = 1'b0;
    chk("j_word", out_instr, 32'hB800_0100);
    out_ready = 1'b1; cyc(); out_ready = 1'b0;

    // Fill past full, then pop and request in the same cycle
    for (int i = 0; i < 5; i++) begin rand_legal(); cyc(); end
    chk("full_level", 32'(level), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1; cyc();
    chk("full_pop_level", 32'(level), 32'd3);
    out_ready = 1'b0; cyc();
    chk("late_accept_level", 32'(level), 32'd4);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    chk("drained_level", 32'(level), 32'd0);
    chk("drained_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Illegal requests
    set_req(6, 1, 1, 2, 3, 4); cyc();
    chk("ill_xori_pulse", 32'(err_pulse), 32'd1);
    set_req(15, 0, 1, 2, 3, 4); cyc(); in_valid = 1'b0;
    chk("ill_c15_pulse", 32'(err_pulse), 32'd1);
    chk("ill_no_write", 32'(level), 32'd0);
`ifdef INSTR_ENC_ERR_CNT_EN
    chk("ill_count", 32'(err_count), 32'd2);
`else
    chk("ill_count", 32'(err_count), 32'd0);
`endif
    cyc();
    chk("ill_pulse_clear", 32'(err_pulse), 32'd0);

    // Reset in the middle of a drain
    for (int i = 0; i < 4; i++) begin rand_legal(); cyc(); end
    in_valid = 1'b0; out_ready = 1'b1; cyc();
    chk("middrain_level", 32'(level), 32'd3);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_errcnt", 32'(err_count), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);

    // Random traffic including illegal requests
    for (int i = 0; i < 400; i++) begin
      int cls;
      cls = $urandom_range(0, 15);
      set_req(cls, $urandom_range(0, 3) == 0, $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
